serial_acc: RTL
===============

SERIAL_ACC -- requirements
Module: serial_acc

Interface
REQ-001 Parameter: WIDTH, default 8, accumulator and operand width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add din into accumulator; sampled only when ready=1.
REQ-005 clr  input  1  synchronous clear of accumulator; sampled only when ready=1.
REQ-006 din  input  WIDTH  unsigned addend, captured on the edge where start is accepted.
REQ-007 ready  output  1  high in IDLE; block accepts start/clr.
REQ-008 done  output  1  one-cycle pulse marking completion of an add.
REQ-009 acc  output  WIDTH  accumulated sum, unsigned; stable except at the update points defined below.
REQ-010 ovf  output  1  carry-out of the most recent completed add.

Function
REQ-011 States IDLE, RUN, DONE; ready = (state==IDLE); done = (state==DONE).
REQ-012 IDLE with clr=1: acc<=0 and ovf<=0; state stays IDLE; start ignored that cycle (clr priority).
REQ-013 IDLE with start=1, clr=0: operand shift reg <= din; working reg <= acc; carry FF <= 0; bit counter <= 0; state -> RUN.
REQ-014 RUN, each cycle: one full-adder evaluation of working[0], operand[0], carry FF; working reg shifts right with sum bit entering MSB; operand shifts right; carry FF <= carry-out; counter increments.
REQ-015 RUN lasts exactly WIDTH cycles; on the edge where counter==WIDTH-1, acc <= completed working value, ovf <= final carry-out, state -> DONE.
REQ-016 DONE lasts exactly one cycle, then state -> IDLE unconditionally.
REQ-017 Latency: start accepted at edge 0 -> RUN cycles 1..WIDTH -> done high in cycle WIDTH+1 with acc/ovf already updated -> ready high in cycle WIDTH+2.
REQ-018 Arithmetic: acc_new = (acc_old + din) mod 2^WIDTH; ovf = 1 iff acc_old + din >= 2^WIDTH.
REQ-019 start and clr in RUN or DONE are ignored, not queued; din changes outside the accept edge have no effect.
REQ-020 start held high continuously: a new add is accepted every WIDTH+2 cycles.
REQ-021 acc and ovf change only on the RUN->DONE edge, on an IDLE clear, or on reset.

Reset
REQ-022 rst=1 at a rising edge forces state=IDLE, acc=0, ovf=0, carry FF=0, counter=0, operand/working regs=0, from any state.
REQ-023 After reset: ready=1, done=0 in the first cycle with rst low.
REQ-024 rst mid-RUN aborts the add: no done pulse, acc=0 (not partial sum).
REQ-025 rst has priority over start and clr.

Structure
REQ-026 Shared package clacc_pkg holds the state encoding typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 Exactly one sub-module instance: fa, the existing one-bit full adder (x, y, cin -> sum, cout), computing the per-cycle bit.
REQ-028 Counter width = clog2(WIDTH); no other arithmetic beyond the counter increment outside fa.

Verification (WIDTH=8)
REQ-029 Reset: assert rst 2 cycles -> acc=0x00, ovf=0, done=0, ready=1 on first cycle after release.
REQ-030 Add sequence: start din=0x05, then start din=0x0A -> done pulses 9 cycles after each accept edge; acc=0x05 then 0x0F; ovf=0 both.
REQ-031 Wrap: acc=0xFF, start din=0x01 -> acc=0x00, ovf=1; next start din=0x01 -> acc=0x01, ovf=0.
REQ-032 Priority/ignore: start+clr same IDLE cycle with acc=0x33 -> acc=0x00, no RUN; start pulsed during RUN cycle 3 -> exactly one done, result unaffected.
REQ-033 Reset mid-operation: acc=0x40, start din=0x11, rst in RUN cycle 4 -> no done, acc=0x00, ready=1 after release.
REQ-034 Back-to-back: start held high, din=0x01, 5 adds from acc=0xFD -> acc sequence 0xFE,0xFF,0x00(ovf=1),0x01,0x02; done spacing 10 cycles.

Source files
------------

// File: rtl/clacc_pkg.sv
// clacc_pkg: shared state encoding and default width for the serial accumulator
package clacc_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fa.sv
// fa: one-bit full adder
module fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_acc.sv
// serial_acc: bit-serial accumulator, one full-adder evaluation per cycle, LSB first
module serial_acc
  import clacc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_work;
  logic             r_ovf;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_next;
  fa u_fa (.x(r_work[0]), .y(r_op[0]), .cin(r_c), .sum(w_sum), .cout(w_cout));
  // sum bits enter at the MSB so after WIDTH shifts the working reg holds the result
  assign w_next = {w_sum, r_work[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_op    <= '0;
      r_work  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (start) begin
            r_op    <= din;
            r_work  <= r_acc;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_work <= w_next;
          r_op   <= r_op >> 1;
          r_c    <= w_cout;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_acc   <= w_next;
            r_ovf   <= w_cout;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);
  assign acc   = r_acc;
  assign ovf   = r_ovf;
endmodule
